router_term_out_fifo: RTL and testbench

Egress FIFO at a router terminal: buffers packets leaving the router fabric and presents them on the terminal bus interface (`pop` / `pndng` / `data_out`) to the downstream consumer. Show-ahead (first-word-fall-through) organisation: the head packet is visible on `data_out` whenever `pndng` is high. It holds `data_out` stable until popped, and never requires a pop without a pending packet. Overflow and underflow attempts are dropped and flagged.

---
 rtl/router_term_out_fifo.sv | 122 ++++++++++++
 tb/tb_router_term_out_fifo.sv | 136 +++++++++++++
 2 files changed

// File: rtl/router_term_out_fifo.sv
// router_term_out_fifo
//
// Egress FIFO at a router terminal. Packets from the router fabric are
// buffered and shown to the terminal consumer in show-ahead
// (first-word-fall-through) form. The head packet sits on data_out whenever
// pndng is high and stays there until it is popped.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous, active-high reset
//   push        in   write request from the fabric
//   data_in     in   packet to write
//   full        out  occupancy == DEPTH
//   almost_full out  occupancy >= AF_LEVEL
//   pop         in   read request from the consumer
//   pndng       out  head packet valid (occupancy != 0)
//   data_out    out  head packet, all-zero when empty
//   count       out  current occupancy
//   overflow    out  one-cycle pulse: a push was dropped
//   underflow   out  one-cycle pulse: a pop was ignored
module router_term_out_fifo #(
  parameter int PCKG_SZ  = 40,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [PCKG_SZ-1:0]         data_in,
  output logic                       full,
  output logic                       almost_full,
  input  logic                       pop,
  output logic                       pndng,
  output logic [PCKG_SZ-1:0]         data_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};

  logic [PCKG_SZ-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               pop_ok_s, push_ok_s;

  // Accept/reject decisions and next-state for pointers, count and error pulses
  always_comb begin
    // Registered count is the only source of truth for empty/full
    pop_ok_s  = pop && (count_q != ZERO_CNT);
    // A full FIFO still takes a push when the head leaves in the same cycle
    push_ok_s = push && ((count_q != FULL_CNT) || pop_ok_s);

    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase

    overflow_d  = push && !push_ok_s;
    underflow_d = pop && !pop_ok_s;
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= ZERO_CNT;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Packet storage; contents need no reset because pndng gates data_out
  always_ff @(posedge clk) begin
    if (!reset && push_ok_s) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // Status and head-packet outputs, decoded from registered state only
  always_comb begin
    count       = count_q;
    pndng       = (count_q != ZERO_CNT);
    full        = (count_q == FULL_CNT);
    almost_full = (count_q >= AF_CNT);
    overflow    = overflow_q;
    underflow   = underflow_q;
    if (count_q != ZERO_CNT) begin
      data_out = mem_q[rd_ptr_q];
    end else begin
      data_out = {PCKG_SZ{1'b0}};
    end
  end

endmodule

// File: tb/tb_router_term_out_fifo.sv
module tb_router_term_out_fifo;

  localparam int PW    = 40;
  localparam int DEPTH = 16;
  localparam int AFL   = 12;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [PW-1:0] data_in = '0;
  logic [PW-1:0] data_out;
  logic          full, almost_full, pndng, overflow, underflow;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  router_term_out_fifo #(.PCKG_SZ(PW), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in),
    .full(full), .almost_full(almost_full), .pop(pop), .pndng(pndng),
    .data_out(data_out), .count(count), .overflow(overflow), .underflow(underflow)
  );

  // Reference model: expected packet order plus expected post-edge status
  logic [PW-1:0] sb_q[$];
  int            m_cnt = 0;
  bit            e_ovf = 1'b0;
  bit            e_unf = 1'b0;

  int            n_chk = 0;
  int            n_pass = 0;
  bit            prev_pndng = 1'b0;
  logic [PW-1:0] prev_data = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // One clock of stimulus; the model is advanced to the state expected after the edge
  task automatic step(input bit p, input logic [PW-1:0] d, input bit q, input bit r);
    bit pok, puok;
    @(negedge clk);
    #1;
    push = p; pop = q; data_in = d; reset = r;
    if (r) begin
      m_cnt = 0; e_ovf = 1'b0; e_unf = 1'b0;
      sb_q.delete();
    end else begin
      pok   = q && (m_cnt != 0);
      puok  = p && ((m_cnt < DEPTH) || pok);
      e_unf = q && (m_cnt == 0);
      e_ovf = p && !puok;
      if (puok) sb_q.push_back(d);
      m_cnt = m_cnt + int'(puok) - int'(pok);
    end
  endtask

  // Monitor: retire popped packets and compare every output against the model
  always @(negedge clk) begin
    logic [PW-1:0] exp_d;
    if (!reset && pop && prev_pndng) begin
      if (sb_q.size() == 0) chk("sb_pop_empty", 64'd1, 64'd0);
      else void'(sb_q.pop_front());
    end
    exp_d = (sb_q.size() > 0) ? sb_q[0] : '0;
    chk("count", 64'(count), 64'(m_cnt));
    chk("pndng", 64'(pndng), 64'(m_cnt != 0));
    chk("full", 64'(full), 64'(m_cnt == DEPTH));
    chk("almost_full", 64'(almost_full), 64'(m_cnt >= AFL));
    chk("overflow", 64'(overflow), 64'(e_ovf));
    chk("underflow", 64'(underflow), 64'(e_unf));
    chk("data_out", 64'(data_out), 64'(exp_d));
    if (prev_pndng && !pop && !reset) chk("hold", 64'(data_out), 64'(prev_data));
    prev_pndng = pndng;
    prev_data  = data_out;
  end

  initial begin
    logic [63:0] rnd;
    bit p, q;
    step(1'b0, '0, 1'b0, 1'b1);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0);

    // Short burst in, then continuous drain
    for (int i = 0; i < 5; i++) step(1'b1, PW'(8'h11 + i), 1'b0, 1'b0);
    repeat (5) step(1'b0, '0, 1'b1, 1'b0);

    // Fill, overflow attempt, drain
    for (int i = 0; i < DEPTH; i++) step(1'b1, PW'(16'h100 + i), 1'b0, 1'b0);
    step(1'b1, PW'(8'hAA), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    repeat (DEPTH) step(1'b0, '0, 1'b1, 1'b0);

    // Fill, push+pop while full, drain
    for (int i = 0; i < DEPTH; i++) step(1'b1, PW'(16'h200 + i), 1'b0, 1'b0);
    step(1'b1, PW'(8'hBB), 1'b1, 1'b0);
    repeat (DEPTH) step(1'b0, '0, 1'b1, 1'b0);

    // Underflow alone, then push+pop while empty
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, PW'(8'h33), 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Random traffic keeping occupancy within 1..DEPTH
    for (int i = 0; i < 40; i++) begin
      rnd = {$urandom(), $urandom()};
      p = ($urandom_range(0, 1) == 1);
      q = ($urandom_range(0, 1) == 1);
      if (m_cnt <= 1 && !p) q = 1'b0;
      if (m_cnt >= DEPTH && !q) p = 1'b0;
      step(p, rnd[PW-1:0], q, 1'b0);
    end

    // Bring occupancy to 7, then reset with push and pop also asserted
    while (m_cnt < 7) begin
      rnd = {$urandom(), $urandom()};
      step(1'b1, rnd[PW-1:0], 1'b0, 1'b0);
    end
    while (m_cnt > 7) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, PW'(8'h77), 1'b1, 1'b1);
    repeat (2) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, PW'(8'h44), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    @(negedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
